sram_controller: RTL

Bridges the data cache's miss/write-through port to the board's external 16-bit asynchronous SRAM. It sits directly downstream of the data cache in the MEM stage. Each cache read is served as one 64-bit block built from four 16-bit SRAM beats. Each cache write is served as one 32-bit word sent as two 16-bit beats. The block holds the cache in its wait state with a `ready` handshake until the SRAM transfer has finished.

---
 rtl/sram_controller.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - data cache to 16-bit async SRAM bridge
// Reads fetch a 64-bit block in four beats; writes send a 32-bit word in two beats.
module sram_controller #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        W_EN,
    input  logic        R_EN,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [63:0] data_out,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      ps, ns;
    logic [3:0]  cyc, cyc_d;
    logic [1:0]  beat, beat_d;
    logic [18:2] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [63:0] dout_d;
    logic [17:0] sram_addr_d;
    logic        we_n_d, oe_n_d;
    logic        dq_en, dq_en_d;
    logic [15:0] dq_out, dq_out_d;

    wire unused_addr_bits = ^{address[31:19], address[1:0]};

    // Every SRAM-facing control is computed one cycle ahead and registered,
    // so the pins never glitch and WE_N can never overlap an address change.
    always_comb begin
        ns          = ps;
        cyc_d       = cyc;
        beat_d      = beat;
        addr_d      = addr_q;
        data_d      = data_q;
        dout_d      = data_out;
        sram_addr_d = SRAM_ADDR;
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        dq_en_d     = 1'b0;
        dq_out_d    = dq_out;
        case (ps)
            IDLE: begin
                if (W_EN) begin
                    ns          = WRITE;
                    addr_d      = address[18:2];
                    data_d      = data_in;
                    cyc_d       = 4'd0;
                    beat_d      = 2'd0;
                    sram_addr_d = {address[18:2], 1'b0};
                    dq_en_d     = 1'b1;
                    dq_out_d    = data_in[15:0];
                    we_n_d      = (LAST == 4'd0);
                end else if (R_EN) begin
                    ns          = READ;
                    addr_d      = address[18:2];
                    cyc_d       = 4'd0;
                    beat_d      = 2'd0;
                    sram_addr_d = {address[18:3], 2'b00};
                    oe_n_d      = 1'b0;
                end
            end
            READ: begin
                oe_n_d = 1'b0;
                if (cyc == LAST) begin
                    dout_d[{beat, 4'b0000} +: 16] = SRAM_DQ;
                    cyc_d  = 4'd0;
                    beat_d = beat + 2'd1;
                    if (beat == 2'd3) begin
                        ns     = DONE;
                        oe_n_d = 1'b1;
                    end else begin
                        sram_addr_d = {addr_q[18:3], beat + 2'd1};
                    end
                end else begin
                    cyc_d = cyc + 4'd1;
                end
            end
            WRITE: begin
                dq_en_d = 1'b1;
                if (cyc == LAST) begin
                    if (beat[0]) begin
                        ns      = DONE;
                        dq_en_d = 1'b0;
                    end else begin
                        cyc_d       = 4'd0;
                        beat_d      = 2'd1;
                        sram_addr_d = {addr_q[18:2], 1'b1};
                        dq_out_d    = data_q[31:16];
                        we_n_d      = (LAST == 4'd0);
                    end
                end else begin
                    cyc_d  = cyc + 4'd1;
                    // WE_N rises for the final cycle of the beat
                    we_n_d = !((cyc + 4'd1) < LAST);
                end
            end
            DONE: ns = IDLE;
            default: ns = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps        <= IDLE;
            cyc       <= 4'd0;
            beat      <= 2'd0;
            addr_q    <= '0;
            data_q    <= 32'd0;
            data_out  <= 64'd0;
            SRAM_ADDR <= 18'd0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            dq_en     <= 1'b0;
            dq_out    <= 16'd0;
        end else begin
            ps        <= ns;
            cyc       <= cyc_d;
            beat      <= beat_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            data_out  <= dout_d;
            SRAM_ADDR <= sram_addr_d;
            SRAM_WE_N <= we_n_d;
            SRAM_OE_N <= oe_n_d;
            dq_en     <= dq_en_d;
            dq_out    <= dq_out_d;
        end
    end

    assign ready     = (ps == DONE) | ((ps == IDLE) & ~W_EN & ~R_EN);
    assign SRAM_DQ   = dq_en ? dq_out : 16'bz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule
